// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute stage and the iterative
// RV32M multiply/divide unit.
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [2:0]      md_op;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            busy;

    modport master (
        output flush, req_valid, in1, in2, md_op, resp_ready,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  flush, req_valid, in1, in2, md_op, resp_ready,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one result bit per cycle, sign fixed up at
// the end. Division by zero and signed overflow finish straight from IDLE.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    md_op_e            op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;

    // Request-side decode
    md_op_e          op_in;
    logic            sgn1, sgn2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_by_zero, sgn_ovf;

    // Iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, mul_fin;
    logic [XLEN:0]     rem_sh, rem_diff;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   final_res;

    // Operand decode at accept: sign handling, magnitudes, special cases
    always_comb begin
        op_in = md_op_e'(bus.md_op);
        sgn1  = (op_in != OP_MULHU) && (op_in != OP_DIVU) && (op_in != OP_REMU) && bus.in1[XLEN-1];
        sgn2  = ((op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM))
                && bus.in2[XLEN-1];
        mag1  = sgn1 ? (~bus.in1 + 1'b1) : bus.in1;
        mag2  = sgn2 ? (~bus.in2 + 1'b1) : bus.in2;
        div_by_zero = bus.md_op[2] && (bus.in2 == '0);
        sgn_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM))
                      && (bus.in1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in2 == '1);
    end

    // One multiply step and one restoring-divide step over the shared accumulator
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        mul_fin  = neg_q ? (~mul_next + 1'b1) : mul_next;

        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (!rem_diff[XLEN])
            div_next = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        div_sel = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];

        if (op_q[2])
            final_res = neg_q ? (~div_sel + 1'b1) : div_sel;
        else if (op_q == OP_MUL)
            final_res = mul_fin[XLEN-1:0];
        else
            final_res = mul_fin[2*XLEN-1:XLEN];
    end

    // Next-state logic; flush overrides accept and response handshake
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        neg_d       = neg_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        resp_data_d = resp_data_q;

        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_d  = op_in;
                        neg_d = (op_in == OP_REM) ? sgn1 : (sgn1 ^ sgn2);
                        cnt_d = '0;
                        // Multiply keeps the multiplicand aside and shifts the
                        // multiplier out of the low half; divide keeps the
                        // divisor aside and shifts the dividend out instead.
                        if (bus.md_op[2]) begin
                            opnd_d = mag2;
                            acc_d  = {{XLEN{1'b0}}, mag1};
                        end else begin
                            opnd_d = mag1;
                            acc_d  = {{XLEN{1'b0}}, mag2};
                        end
                        if (div_by_zero) begin
                            resp_data_d = bus.md_op[1] ? bus.in1 : '1;
                            state_d     = S_DONE;
                        end else if (sgn_ovf) begin
                            resp_data_d = bus.md_op[1] ? '0 : bus.in1;
                            state_d     = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    if (cnt_q == CW'(XLEN-1)) begin
                        resp_data_d = final_res;
                        state_d     = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_MUL;
            neg_q       <= 1'b0;
            opnd_q      <= '0;
            acc_q       <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_DONE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector and randomized bench for mul_div_unit.
module tb_mul_div_unit;
    localparam int XLEN = 32;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mul_div_unit_if #(.XLEN(XLEN)) bus ();

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sx, sy;
        logic [63:0]        p;
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            3'd0, 3'd1: begin
                sx = {{32{a[31]}}, a};
                sy = {{32{b[31]}}, b};
                p  = sx * sy;
            end
            3'd2: begin
                sx = {{32{a[31]}}, a};
                sy = {32'h0, b};
                p  = sx * sy;
            end
            3'd3: p = {32'h0, a} * {32'h0, b};
            default: p = '0;
        endcase
        case (op)
            3'd0:    return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one request from IDLE and wait (bounded) for its response.
    // lat = edges after the accept edge until resp_valid is seen, -1 on timeout.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit rr_high, input int stall,
                          output logic [31:0] data, output int lat);
        bus.md_op      = op;
        bus.in1        = a;
        bus.in2        = b;
        bus.req_valid  = 1'b1;
        bus.resp_ready = rr_high;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.resp_valid) lat = -1;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        data = bus.resp_data;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    vec_t        vecs[19];
    logic [31:0] data;
    int          lat;
    bit          seen;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.flush      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.in1        = '0;
        bus.in2        = '0;
        bus.md_op      = '0;
        bus.resp_ready = 1'b0;

        vecs[0]  = '{3'd0, 32'd26,        32'd13,        32'd338,       32};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32};
        vecs[4]  = '{3'd4, 32'd26,        32'd13,        32'd2,         32};
        vecs[5]  = '{3'd6, 32'd26,        32'd13,        32'd0,         32};
        vecs[6]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32};
        vecs[7]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32};
        vecs[8]  = '{3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32};
        vecs[9]  = '{3'd4, 32'd26,        32'd0,         32'hFFFF_FFFF, 0};
        vecs[10] = '{3'd7, 32'd26,        32'd0,         32'd26,        0};
        vecs[11] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
        vecs[12] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0};
        vecs[13] = '{3'd0, 32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFF9, 32};
        vecs[14] = '{3'd7, 32'd100,       32'd7,         32'd2,         32};
        vecs[15] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32};
        vecs[16] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32};
        vecs[17] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32};
        vecs[18] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         32};

        // Reset state while rst_n is low
        #12;
        chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data",  bus.resp_data,       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, consumer always ready
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 0, data, lat);
            chk($sformatf("vec%0d_data", i), data, vecs[i].exp);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_idle", i), 32'(bus.busy), 32'd0);
        end

        // Backpressure: response held for 10 cycles, new request ignored
        bus.md_op = 3'd0; bus.in1 = 32'd26; bus.in2 = 32'd13;
        bus.req_valid = 1'b1; bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_lat",  32'(lat),       32'd32);
        chk("bp_data", bus.resp_data,  32'd338);
        bus.md_op = 3'd0; bus.in1 = 32'd1; bus.in2 = 32'd1; bus.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_data",  bus.resp_data,        32'd338);
            chk("bp_req_ready",  32'(bus.req_ready),   32'd0);
            chk("bp_resp_valid", 32'(bus.resp_valid),  32'd1);
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("bp_rel_busy",      32'(bus.busy),       32'd0);
        chk("bp_rel_req_ready", 32'(bus.req_ready),  32'd1);
        chk("bp_rel_valid",     32'(bus.resp_valid), 32'd0);
        chk("bp_rel_data",      bus.resp_data,       32'd338);

        // Flush at cycle 10 of a DIV
        bus.md_op = 3'd4; bus.in1 = 32'd1000; bus.in2 = 32'd7; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("fl_busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("fl_busy",  32'(bus.busy),       32'd0);
        chk("fl_valid", 32'(bus.resp_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= bus.resp_valid;
        end
        chk("fl_no_resp", 32'(seen), 32'd0);

        // Flush in IDLE blocks a pending request
        bus.flush = 1'b1; bus.req_valid = 1'b1; bus.md_op = 3'd0;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.req_valid = 1'b0;
        chk("fl_idle_no_accept", 32'(bus.busy), 32'd0);
        run_op(3'd0, 32'd3, 32'd4, 1'b1, 0, data, lat);
        chk("fl_after_data", data,     32'd12);
        chk("fl_after_lat",  32'(lat), 32'd32);

        // Asynchronous reset mid-CALC
        bus.md_op = 3'd0; bus.in1 = 32'd5; bus.in2 = 32'd5; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",      32'(bus.busy),       32'd0);
        chk("arst_req_ready", 32'(bus.req_ready),  32'd1);
        chk("arst_valid",     32'(bus.resp_valid), 32'd0);
        chk("arst_data",      bus.resp_data,       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= bus.resp_valid;
        end
        chk("arst_no_resp", 32'(seen), 32'd0);

        // Randomized operations with random response stalls
        for (int n = 0; n < 2000; n++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            bit          rr;
            int          st, exp_lat;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            rr = 1'($urandom_range(0, 1));
            st = rr ? 0 : $urandom_range(0, 3);
            exp_lat = (op[2] && (b == 0)) ||
                      ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : 32;
            run_op(op, a, b, rr, st, data, lat);
            chk($sformatf("rnd%0d_op%0d_%h_%h", n, op, a, b), data, golden(op, a, b));
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(exp_lat));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
